// File: rtl/i2c_sda_sequencer.sv
// SDA phase sequencer for the I2C master: counts data/ACK slots from SCL edge
// strobes, serialises tx words, deserialises rx words and watches for arbitration loss.
module i2c_sda_sequencer #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              scl_rise,
  input  logic              scl_fall,
  input  logic              start_det,
  input  logic              stop_det,
  input  logic              sda_in,
  output logic              sda_oe,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              master_ack,
  output logic              slave_ack,
  output logic              ack_valid,
  output logic              underrun,
  output logic              arb_lost,
  output logic              rw_o,
  output logic [1:0]        phase
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    ACK  = 2'd2,
    HOLD = 2'd3
  } phase_t;

  localparam int CW = (DATA_W > 2) ? $clog2(DATA_W) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_W - 1);

  phase_t            state;
  logic [CW-1:0]     bit_cnt;
  logic              first;
  logic              ack_master;
  logic              buf_full;
  logic [DATA_W-1:0] buf_q;
  logic [DATA_W-1:0] shift_q;
  logic [DATA_W-2:0] rx_shift;
  logic [DATA_W-1:0] rx_next;
  logic              fall_ev;
  logic              rise_ev;
  logic              master_drv;
  logic              consume;

  // Coincident SCL strobes are contradictory and both are dropped.
  assign fall_ev    = scl_fall & ~scl_rise;
  assign rise_ev    = scl_rise & ~scl_fall;
  assign master_drv = first | ~rw_o;
  assign rx_next    = {rx_shift, sda_in};
  assign phase      = state;

  // tx handshake: a word is accepted on any clk where tx_valid && tx_ready;
  // tx_ready is high exactly while the single holding buffer is empty.
  assign tx_ready = ~buf_full;

  assign consume = (state == DATA) && fall_ev && (bit_cnt == '0) && master_drv &&
                   buf_full && !start_det && !stop_det;

  always_ff @(posedge clk) begin
    if (reset) begin
      buf_full <= 1'b0;
      buf_q    <= '0;
    end else begin
      if (consume)
        buf_full <= 1'b0;
      if (tx_valid && tx_ready) begin
        buf_q    <= tx_data;
        buf_full <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      first      <= 1'b0;
      ack_master <= 1'b0;
      rw_o       <= 1'b0;
      shift_q    <= '1;
      rx_shift   <= '0;
      sda_oe     <= 1'b0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      slave_ack  <= 1'b0;
      ack_valid  <= 1'b0;
      underrun   <= 1'b0;
      arb_lost   <= 1'b0;
    end else begin
      rx_valid  <= 1'b0;
      ack_valid <= 1'b0;
      underrun  <= 1'b0;
      arb_lost  <= 1'b0;
      if (start_det) begin
        state   <= DATA;
        bit_cnt <= '0;
        first   <= 1'b1;
        rw_o    <= 1'b0;
        sda_oe  <= 1'b0;
      end else if (stop_det) begin
        state  <= IDLE;
        sda_oe <= 1'b0;
      end else begin
        case (state)
          IDLE: sda_oe <= 1'b0;
          DATA: begin
            if (fall_ev) begin
              if (master_drv) begin
                if (bit_cnt == '0) begin
                  // An empty buffer sends all ones so the bus is simply released.
                  if (buf_full) begin
                    shift_q <= buf_q;
                    sda_oe  <= ~buf_q[DATA_W-1];
                  end else begin
                    shift_q  <= '1;
                    sda_oe   <= 1'b0;
                    underrun <= 1'b1;
                  end
                end else begin
                  sda_oe <= ~shift_q[DATA_W-1];
                end
              end else begin
                sda_oe <= 1'b0;
              end
            end else if (rise_ev) begin
              if (master_drv && !sda_oe && !sda_in) begin
                arb_lost <= 1'b1;
                sda_oe   <= 1'b0;
                state    <= HOLD;
              end else begin
                rx_shift <= rx_next[DATA_W-2:0];
                shift_q  <= shift_q << 1;
                if (bit_cnt == LAST_BIT) begin
                  bit_cnt    <= '0;
                  rx_data    <= rx_next;
                  rx_valid   <= 1'b1;
                  ack_master <= master_drv;
                  if (first) begin
                    rw_o  <= sda_in;
                    first <= 1'b0;
                  end
                  state <= ACK;
                end else begin
                  bit_cnt <= bit_cnt + CW'(1);
                end
              end
            end
          end
          ACK: begin
            // ack_master remembers who drove the data bits of the frame just ended.
            if (fall_ev) begin
              sda_oe <= ack_master ? 1'b0 : ~master_ack;
            end else if (rise_ev) begin
              bit_cnt <= '0;
              if (ack_master) begin
                slave_ack <= ~sda_in;
                ack_valid <= 1'b1;
                state     <= sda_in ? HOLD : DATA;
              end else begin
                state <= master_ack ? HOLD : DATA;
              end
            end
          end
          HOLD: sda_oe <= 1'b0;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_sda_sequencer.sv
// Bench for i2c_sda_sequencer: drives SCL strobes and a wired-AND bus model,
// checks rx words and slave ACKs through expected queues, slot behaviour inline.
module tb_i2c_sda_sequencer;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         scl_rise = 1'b0, scl_fall = 1'b0, start_det = 1'b0, stop_det = 1'b0;
  logic         sda_in = 1'b1;
  logic         sda_oe;
  logic [W-1:0] tx_data = '0;
  logic         tx_valid = 1'b0;
  logic         tx_ready;
  logic [W-1:0] rx_data;
  logic         rx_valid;
  logic         master_ack = 1'b0;
  logic         slave_ack, ack_valid, underrun, arb_lost, rw_o;
  logic [1:0]   phase;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_rx_q[$];
  logic         exp_ack_q[$];
  logic [W-1:0] mon_rx_e;
  logic         mon_ack_e;

  logic       obs_oe[9], obs_und[9], obs_rdy[9], obs_arb[9];
  logic [1:0] obs_ph[9];

  always #5 clk = ~clk;

  i2c_sda_sequencer #(.DATA_W(W)) dut (
    .clk(clk), .reset(reset), .scl_rise(scl_rise), .scl_fall(scl_fall),
    .start_det(start_det), .stop_det(stop_det), .sda_in(sda_in), .sda_oe(sda_oe),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .master_ack(master_ack),
    .slave_ack(slave_ack), .ack_valid(ack_valid), .underrun(underrun),
    .arb_lost(arb_lost), .rw_o(rw_o), .phase(phase)
  );

  // Scoreboard: every rx_valid / ack_valid pops one expectation.
  always @(negedge clk) begin
    if (rx_valid) begin
      checks++;
      if (exp_rx_q.size() == 0) begin
        errors++;
        $display("FAIL rx_unexpected got %h want no word", rx_data);
      end else begin
        mon_rx_e = exp_rx_q.pop_front();
        if (rx_data !== mon_rx_e) begin
          errors++;
          $display("FAIL rx_data got %h want %h", rx_data, mon_rx_e);
        end
      end
    end
    if (ack_valid) begin
      checks++;
      if (exp_ack_q.size() == 0) begin
        errors++;
        $display("FAIL ack_unexpected got %b want no ack", slave_ack);
      end else begin
        mon_ack_e = exp_ack_q.pop_front();
        if (slave_ack !== mon_ack_e) begin
          errors++;
          $display("FAIL slave_ack got %b want %b", slave_ack, mon_ack_e);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks (all start and end on a negedge) ----------------
  task automatic strobe_start();
    start_det = 1'b1; @(negedge clk); start_det = 1'b0;
  endtask

  task automatic strobe_stop();
    stop_det = 1'b1; @(negedge clk); stop_det = 1'b0; @(negedge clk);
  endtask

  task automatic strobe_fall();
    scl_fall = 1'b1; @(negedge clk); scl_fall = 1'b0;
  endtask

  task automatic load_tx(input logic [W-1:0] w);
    int n;
    n = 0;
    while (!tx_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (tx_ready !== 1'b1) begin
      errors++;
      $display("FAIL load_timeout tx_ready got %b want 1", tx_ready);
    end
    tx_data = w; tx_valid = 1'b1; @(negedge clk); tx_valid = 1'b0;
  endtask

  // Runs nbits SCL slots; lvl_bits is what the slave leaves on the bus per data bit,
  // ack_lvl its level in the ACK slot. Bus = slave level AND NOT sda_oe.
  task automatic drive_frame(input int nbits, input logic [W-1:0] lvl_bits, input logic ack_lvl);
    logic lvl;
    for (int i = 0; i < nbits; i++) begin
      strobe_fall();
      obs_oe[i] = sda_oe; obs_und[i] = underrun; obs_rdy[i] = tx_ready;
      @(negedge clk);
      if (i < W) lvl = lvl_bits[W-1-i];
      else lvl = ack_lvl;
      sda_in = lvl & ~sda_oe;
      scl_rise = 1'b1; @(negedge clk); scl_rise = 1'b0;
      obs_arb[i] = arb_lost; obs_ph[i] = phase;
      @(negedge clk);
      sda_in = 1'b1;
    end
  endtask

  // ---------------- test tasks ----------------
  task automatic test_reset();
    reset = 1'b1; repeat (3) @(negedge clk); reset = 1'b0; @(negedge clk);
    checks++;
    if ({sda_oe, tx_ready, rx_valid, slave_ack, ack_valid, underrun, arb_lost, rw_o} !== 8'b0100_0000) begin
      errors++;
      $display("FAIL reset_flags got %b want 01000000",
               {sda_oe, tx_ready, rx_valid, slave_ack, ack_valid, underrun, arb_lost, rw_o});
    end
    checks++;
    if (rx_data !== '0 || phase !== 2'd0) begin
      errors++;
      $display("FAIL reset_rx_phase got %h/%0d want 00/0", rx_data, phase);
    end
  endtask

  task automatic test_write();
    logic [W-1:0] words[2];
    words[0] = 8'hA0; words[1] = 8'h5C;
    load_tx(words[0]);
    checks++;
    if (tx_ready !== 1'b0) begin errors++; $display("FAIL wr_buf_full tx_ready got %b want 0", tx_ready); end
    strobe_start();
    checks++;
    if (phase !== 2'd1 || sda_oe !== 1'b0) begin
      errors++; $display("FAIL wr_start phase/oe got %0d/%b want 1/0", phase, sda_oe);
    end
    for (int f = 0; f < 2; f++) begin
      if (f == 1) load_tx(words[1]);
      exp_rx_q.push_back(words[f]); exp_ack_q.push_back(1'b1);
      drive_frame(9, 8'hFF, 1'b0);
      for (int i = 0; i < W; i++) begin
        checks++;
        if (obs_oe[i] !== ~words[f][W-1-i]) begin
          errors++; $display("FAIL wr_bit f%0d b%0d sda_oe got %b want %b", f, i, obs_oe[i], ~words[f][W-1-i]);
        end
      end
      checks++;
      if (obs_oe[8] !== 1'b0) begin errors++; $display("FAIL wr_ack_slot f%0d sda_oe got %b want 0", f, obs_oe[8]); end
    end
    checks++;
    if (rw_o !== 1'b0 || phase !== 2'd1) begin
      errors++; $display("FAIL wr_end rw/phase got %b/%0d want 0/1", rw_o, phase);
    end
    strobe_stop();
    checks++;
    if (phase !== 2'd0) begin errors++; $display("FAIL wr_stop phase got %0d want 0", phase); end
  endtask

  task automatic test_read();
    load_tx(8'hA1);
    strobe_start();
    exp_rx_q.push_back(8'hA1); exp_ack_q.push_back(1'b1);
    drive_frame(9, 8'hFF, 1'b0);
    checks++;
    if (rw_o !== 1'b1) begin errors++; $display("FAIL rd_rw got %b want 1", rw_o); end
    master_ack = 1'b0;
    exp_rx_q.push_back(8'h3C);
    drive_frame(9, 8'h3C, 1'b1);
    for (int i = 0; i < W; i++) begin
      checks++;
      if (obs_oe[i] !== 1'b0 || obs_und[i] !== 1'b0) begin
        errors++; $display("FAIL rd_data b%0d oe/und got %b/%b want 0/0", i, obs_oe[i], obs_und[i]);
      end
    end
    checks++;
    if (obs_oe[8] !== 1'b1) begin errors++; $display("FAIL rd_mack_slot sda_oe got %b want 1", obs_oe[8]); end
    master_ack = 1'b1;
    exp_rx_q.push_back(8'hC3);
    drive_frame(9, 8'hC3, 1'b1);
    checks++;
    if (obs_oe[8] !== 1'b0 || obs_ph[8] !== 2'd3) begin
      errors++; $display("FAIL rd_nack_slot oe/phase got %b/%0d want 0/3", obs_oe[8], obs_ph[8]);
    end
    master_ack = 1'b0;
    strobe_stop();
  endtask

  task automatic test_addr_nack();
    load_tx(8'hA0);
    strobe_start();
    exp_rx_q.push_back(8'hA0); exp_ack_q.push_back(1'b0);
    drive_frame(9, 8'hFF, 1'b1);
    checks++;
    if (phase !== 2'd3 || sda_oe !== 1'b0) begin
      errors++; $display("FAIL nack_hold phase/oe got %0d/%b want 3/0", phase, sda_oe);
    end
    strobe_stop();
    checks++;
    if (phase !== 2'd0) begin errors++; $display("FAIL nack_stop phase got %0d want 0", phase); end
  endtask

  task automatic test_underrun();
    load_tx(8'hA0);
    strobe_start();
    exp_rx_q.push_back(8'hA0); exp_ack_q.push_back(1'b1);
    drive_frame(9, 8'hFF, 1'b0);
    exp_rx_q.push_back(8'hFF); exp_ack_q.push_back(1'b1);
    drive_frame(9, 8'hFF, 1'b0);
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (obs_und[i] !== (i == 0) || obs_oe[i] !== 1'b0 || obs_rdy[i] !== 1'b1) begin
        errors++;
        $display("FAIL underrun_slot%0d und/oe/rdy got %b/%b/%b want %b/0/1",
                 i, obs_und[i], obs_oe[i], obs_rdy[i], (i == 0));
      end
    end
    strobe_stop();
  endtask

  task automatic test_arb_loss();
    load_tx(8'hFF);
    strobe_start();
    drive_frame(9, 8'b1111_1011, 1'b0);
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (obs_arb[i] !== (i == 5) || obs_oe[i] !== 1'b0) begin
        errors++; $display("FAIL arb_slot%0d arb/oe got %b/%b want %b/0", i, obs_arb[i], obs_oe[i], (i == 5));
      end
    end
    checks++;
    if (obs_ph[5] !== 2'd3 || phase !== 2'd3) begin
      errors++; $display("FAIL arb_phase got %0d/%0d want 3/3", obs_ph[5], phase);
    end
    strobe_stop();
  endtask

  task automatic test_reset_mid_frame();
    load_tx(8'hA0);
    strobe_start();
    drive_frame(4, 8'hFF, 1'b0);
    load_tx(8'h55);
    strobe_fall();
    checks++;
    if (sda_oe !== 1'b1 || tx_ready !== 1'b0) begin
      errors++; $display("FAIL rstmid_pre oe/rdy got %b/%b want 1/0", sda_oe, tx_ready);
    end
    reset = 1'b1; @(negedge clk); reset = 1'b0;
    checks++;
    if (sda_oe !== 1'b0 || phase !== 2'd0 || tx_ready !== 1'b1) begin
      errors++; $display("FAIL rstmid_post oe/phase/rdy got %b/%0d/%b want 0/0/1", sda_oe, phase, tx_ready);
    end
    @(negedge clk);
  endtask

  task automatic test_restart_mid_byte();
    logic [W-1:0] w;
    load_tx(8'hA0);
    strobe_start();
    drive_frame(3, 8'hFF, 1'b0);
    strobe_fall();
    @(negedge clk);
    strobe_start();
    checks++;
    if (phase !== 2'd1 || sda_oe !== 1'b0 || rw_o !== 1'b0) begin
      errors++; $display("FAIL rs_start phase/oe/rw got %0d/%b/%b want 1/0/0", phase, sda_oe, rw_o);
    end
    w = 8'hA1;
    load_tx(w);
    exp_rx_q.push_back(w); exp_ack_q.push_back(1'b1);
    drive_frame(9, 8'hFF, 1'b0);
    for (int i = 0; i < W; i++) begin
      checks++;
      if (obs_oe[i] !== ~w[W-1-i]) begin
        errors++; $display("FAIL rs_bit%0d sda_oe got %b want %b", i, obs_oe[i], ~w[W-1-i]);
      end
    end
    checks++;
    if (rw_o !== 1'b1) begin errors++; $display("FAIL rs_rw got %b want 1", rw_o); end
    strobe_stop();
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_addr_nack();
    test_underrun();
    test_arb_loss();
    test_reset_mid_frame();
    test_restart_mid_byte();
    repeat (3) @(negedge clk);
    checks++;
    if (exp_rx_q.size() != 0 || exp_ack_q.size() != 0) begin
      errors++; $display("FAIL scoreboard_left rx %0d ack %0d want 0 0", exp_rx_q.size(), exp_ack_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/i2c_sda_sequencer.md
# i2c_sda_sequencer

Parametrised SDA phase sequencer for the I2C master; it replaces static decode-driven SDA steering with a bit-counting state machine. It tracks data and acknowledge slots from SCL edge strobes and takes the bus direction from the address frame. It serialises transmit words, deserialises receive words, drives or samples the acknowledge bit, and detects arbitration loss. It sits between the byte-level controller and the open-drain SDA pad.

## Interface
- DATA_W, 8, bits per frame before the ACK slot (minimum 2)
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- scl_rise  in  1  one-cycle strobe: SCL rising edge (sample point)
- scl_fall  in  1  one-cycle strobe: SCL falling edge (drive-change point)
- start_det  in  1  one-cycle strobe: START or repeated START seen
- stop_det  in  1  one-cycle strobe: STOP seen
- sda_in  in  1  synchronised SDA pad level
- sda_oe  out  1  1 = pull SDA low; 0 = release
- tx_data  in  DATA_W  next word to transmit, MSB first
- tx_valid  in  1  tx_data valid
- tx_ready  out  1  holding buffer empty
- rx_data  out  DATA_W  last received frame
- rx_valid  out  1  one-cycle pulse: rx_data updated
- master_ack  in  1  ACK bit for read frames: 0 = ACK, 1 = NACK
- slave_ack  out  1  1 = slave ACKed the last write frame
- ack_valid  out  1  one-cycle pulse: slave_ack updated
- underrun  out  1  one-cycle pulse: master-driven frame began with an empty buffer
- arb_lost  out  1  one-cycle pulse: arbitration lost
- rw_o  out  1  latched direction: 0 = write, 1 = read
- phase  out  2  0 = IDLE, 1 = DATA, 2 = ACK, 3 = HOLD

## Operation
- Single-word tx holding buffer.
  - tx_ready = ~buf_full.
  - tx_valid && tx_ready sets buf_full.
  - If a write and a consume occur in the same cycle, the old word is consumed and the new word is held.
  - There is no bypass into an empty buffer.
- A frame is master-driven if it is the first frame after START, or if rw_o = 0. Otherwise it is slave-driven.
- IDLE:
  - sda_oe = 0.
  - start_det → DATA with bit_cnt = 0, first = 1, rw_o = 0.
- DATA:
  - scl_fall with bit_cnt = 0 and a master-driven frame:
    - buf_full → shift ← buf, buf_full ← 0.
    - buf empty → shift ← all ones, underrun pulses.
  - scl_fall in a master-driven frame: sda_oe ← ~shift[MSB].
  - scl_fall in a slave-driven frame: sda_oe ← 0.
  - scl_rise:
    - rx shifts in sda_in.
    - tx shifts left.
    - bit_cnt increments.
  - Arbitration check: a master-driven bit with sda_oe = 0 and sampled sda_in = 0 → arb_lost pulses, HOLD.
  - scl_rise on bit DATA_W-1:
    - rx_data updates and rx_valid pulses.
    - If first = 1, rw_o ← sampled bit; first ← 0.
    - → ACK.
- ACK:
  - scl_fall:
    - Previous frame master-driven → sda_oe ← 0.
    - Previous frame slave-driven → sda_oe ← ~master_ack.
  - scl_rise, previous frame master-driven:
    - slave_ack ← ~sda_in; ack_valid pulses.
    - NACK → HOLD.
  - scl_rise, previous frame slave-driven: master_ack = 1 → HOLD.
  - Otherwise → DATA with bit_cnt = 0.
- HOLD:
  - sda_oe = 0.
  - Waits for start_det or stop_det.
- Global event priority: reset > start_det > stop_det > SCL strobes.
  - start_det in any state → DATA with bit_cnt = 0, first = 1, rw_o = 0, sda_oe ← 0. buf is preserved.
  - stop_det in any state → IDLE, sda_oe ← 0.
  - scl_rise and scl_fall in the same cycle: both are ignored.
- Reset mid-frame abandons the frame and empties buf.

## Timing
- All outputs are registered except tx_ready, which is decoded from the buf_full register.
- Reset values:
  - sda_oe 0, tx_ready 1, rx_data 0, rx_valid 0.
  - slave_ack 0, ack_valid 0, underrun 0, arb_lost 0.
  - rw_o 0, phase 0.
- sda_oe changes one clk after scl_fall.
- rx_valid, ack_valid and arb_lost pulse one clk after the triggering scl_rise.
- underrun pulses one clk after scl_fall.
- start_det and stop_det take effect one clk later: phase and sda_oe update together.
- SCL strobes are assumed at least 2 clk apart.

## Test plan
- Write transaction:
  - Stimulus: load 0xA0 then 0x5C; start_det; 18 SCL pulses with the slave ACKing both frames.
  - Required: sda_oe = ~bits of 0xA0 then 0x5C. sda_oe = 0 in both ACK slots. ack_valid ×2 with slave_ack = 1. rw_o = 0.
- Read transaction:
  - Stimulus: load 0xA1; the slave drives 0x3C then 0xC3; master_ack = 0 then 1.
  - Required: rx_valid with rx_data = 0xA1, then 0x3C, then 0xC3. rw_o = 1. sda_oe = 1 only in the first read ACK slot. phase = 3 after the second.
- Address NACK:
  - Stimulus: the slave leaves SDA high in the ACK slot.
  - Required: slave_ack = 0, ack_valid, phase = 3, sda_oe = 0. A subsequent stop_det gives phase = 0.
- Underrun:
  - Stimulus: after the address ACK, no tx_valid.
  - Required: underrun pulse one clk after the first scl_fall. sda_oe stays 0 for 8 bits. tx_ready = 1 throughout.
- Arbitration loss:
  - Stimulus: transmit 0xFF while bit 5 is sampled 0.
  - Required: arb_lost pulse, phase = 3, sda_oe = 0 from then on.
- Reset and repeated START mid-frame:
  - Stimulus: reset during bit 4 with sda_oe = 1.
  - Required: next clk sda_oe = 0, phase = 0, tx_ready = 1.
  - Stimulus: start_det mid-byte in a separate transaction.
  - Required: phase = 1, bit count restarts, and the next frame is treated as the address frame.
